// File: rtl/decode_pkg.sv
// decode_pkg
//   Shared types and constants for the decode_field_stage slice.
//   - fmt_e        : per-lane instruction format code (3 bits)
//   - OP_*         : full 7-bit opcode constants recognised by the decoder
//   - lane_res_t   : one lane's decoded result. The immediate is always carried
//                    at 64 bits so the package stays independent of XLEN; the
//                    stage keeps the low XLEN bits, which are already correctly
//                    sign-extended for either XLEN choice.
package decode_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6,
        FMT_ILL  = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    localparam int IMM_W = 64;

    typedef struct packed {
        fmt_e             fmt;
        logic             illegal;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [IMM_W-1:0] imm;
    } lane_res_t;

endpackage

// File: rtl/decode_lane.sv
// decode_lane
//   Purely combinational single-lane decoder: classifies a 32-bit instruction
//   by its full opcode, extracts register/function fields and assembles the
//   sign-extended immediate.
//   Ports:
//     instr   in   32-bit raw instruction
//     lane_en in   lane carries a real instruction (from the bundle mask)
//     res     out  decoded lane result (decode_pkg::lane_res_t)
module decode_lane
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        lane_en,
    output lane_res_t   res
);

    // Disabled lanes report NONE with every field zero; enabled lanes always
    // expose their register fields, even when the opcode is unknown.
    always_comb begin
        res = '0;
        if (lane_en) begin
            res.rd     = instr[11:7];
            res.funct3 = instr[14:12];
            res.rs1    = instr[19:15];
            res.rs2    = instr[24:20];
            res.funct7 = instr[31:25];
            case (instr[6:0])
                OP_OP, OP_OP_32: begin
                    res.fmt = FMT_R;
                end
                OP_IMM, OP_IMM_32, OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM: begin
                    res.fmt = FMT_I;
                    res.imm = {{52{instr[31]}}, instr[31:20]};
                end
                OP_STORE: begin
                    res.fmt = FMT_S;
                    res.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
                end
                OP_BRANCH: begin
                    res.fmt = FMT_B;
                    res.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                               instr[11:8], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    res.fmt = FMT_U;
                    res.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
                end
                OP_JAL: begin
                    res.fmt = FMT_J;
                    res.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                               instr[30:21], 1'b0};
                end
                default: begin
                    res.fmt     = FMT_ILL;
                    res.illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/decode_field_stage.sv
// decode_field_stage
//   Registered multi-lane decode stage between the fetch queue and rename.
//   Each accepted bundle of LANES instructions is decoded combinationally and
//   written into a DEPTH-entry FIFO; the head entry drives the out_* ports.
//   Parameters: LANES (1..4), XLEN (32/64), DEPTH (power of two, >= 2).
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     in_valid/in_ready        upstream handshake (in_ready from state only)
//     in_instr, in_mask        raw lanes and lane-valid mask
//     out_valid/out_ready      downstream handshake
//     out_mask, out_fmt, out_illegal, out_rs1, out_rs2, out_rd,
//     out_funct3, out_funct7, out_imm   per-lane decoded head bundle
//   Optional macro DECODE_FIELD_STAGE_PERF_EN adds perf_bundles (accepted
//   bundles) and perf_stall (cycles with in_valid & !in_ready), both 32-bit
//   wrapping counters.
module decode_field_stage
    import decode_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   in_instr,
    input  logic [LANES-1:0]      in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_mask,
    output logic [LANES*3-1:0]    out_fmt,
    output logic [LANES-1:0]      out_illegal,
    output logic [LANES*5-1:0]    out_rs1,
    output logic [LANES*5-1:0]    out_rs2,
    output logic [LANES*5-1:0]    out_rd,
    output logic [LANES*3-1:0]    out_funct3,
    output logic [LANES*7-1:0]    out_funct7,
    output logic [LANES*XLEN-1:0] out_imm
`ifdef DECODE_FIELD_STAGE_PERF_EN
    ,
    output logic [31:0]           perf_bundles,
    output logic [31:0]           perf_stall
`endif
);

    localparam int AW = $clog2(DEPTH);

    lane_res_t        lane_res [LANES];
    lane_res_t        mem      [DEPTH][LANES];
    logic [LANES-1:0] mask_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    show_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        decode_lane u_lane (
            .instr   (in_instr[32*i +: 32]),
            .lane_en (in_mask[i]),
            .res     (lane_res[i])
        );
    end

    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // When the FIFO is empty the slot just behind rd_ptr is the last popped
    // bundle. Nothing writes it until the next push (which lands at rd_ptr),
    // so pointing there keeps the data outputs at their last value.
    assign show_ptr = (count == '0) ? (rd_ptr - AW'(1)) : rd_ptr;

    // FIFO storage, pointers and occupancy. Reset clears the storage too so
    // every out_* data port reads zero and no stale bundle can resurface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                mask_mem[d] <= '0;
                for (int l = 0; l < LANES; l++) begin
                    mem[d][l] <= '0;
                end
            end
        end else begin
            if (push) begin
                mask_mem[wr_ptr] <= in_mask;
                for (int l = 0; l < LANES; l++) begin
                    mem[wr_ptr][l] <= lane_res[l];
                end
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_mask = mask_mem[show_ptr];

    for (genvar i = 0; i < LANES; i++) begin : g_out
        assign out_fmt[3*i +: 3]       = mem[show_ptr][i].fmt;
        assign out_illegal[i]          = mem[show_ptr][i].illegal;
        assign out_rs1[5*i +: 5]       = mem[show_ptr][i].rs1;
        assign out_rs2[5*i +: 5]       = mem[show_ptr][i].rs2;
        assign out_rd[5*i +: 5]        = mem[show_ptr][i].rd;
        assign out_funct3[3*i +: 3]    = mem[show_ptr][i].funct3;
        assign out_funct7[7*i +: 7]    = mem[show_ptr][i].funct7;
        assign out_imm[XLEN*i +: XLEN] = mem[show_ptr][i].imm[XLEN-1:0];
    end

`ifdef DECODE_FIELD_STAGE_PERF_EN
    // Free-running wrap-around counters of accepted bundles and of cycles
    // where upstream offered a bundle that the full FIFO had to refuse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bundles <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) begin
                perf_bundles <= perf_bundles + 32'd1;
            end
            if (in_valid && !in_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_field_stage.sv
// tb_decode_field_stage
//   Self-checking bench for decode_field_stage (LANES=2, XLEN=32, DEPTH=2).
//   A queue of raw bundles models the FIFO; expected decode results are
//   computed from the instruction-format rules at check time.
//   With DECODE_FIELD_STAGE_PERF_EN defined the perf counters are checked too.
module tb_decode_field_stage;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [LANES*32-1:0]   in_instr = '0;
    logic [LANES-1:0]      in_mask = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [LANES-1:0]      out_mask;
    logic [LANES*3-1:0]    out_fmt;
    logic [LANES-1:0]      out_illegal;
    logic [LANES*5-1:0]    out_rs1;
    logic [LANES*5-1:0]    out_rs2;
    logic [LANES*5-1:0]    out_rd;
    logic [LANES*3-1:0]    out_funct3;
    logic [LANES*7-1:0]    out_funct7;
    logic [LANES*XLEN-1:0] out_imm;
`ifdef DECODE_FIELD_STAGE_PERF_EN
    logic [31:0]           perf_bundles;
    logic [31:0]           perf_stall;
`endif

    decode_field_stage #(.LANES(LANES), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_mask     (in_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_mask    (out_mask),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm)
`ifdef DECODE_FIELD_STAGE_PERF_EN
        ,
        .perf_bundles(perf_bundles),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*32-1:0] instr;
        logic [LANES-1:0]    mask;
    } bundle_t;

    typedef struct {
        int          fmt;
        bit          ill;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
    } exp_t;

    bundle_t q[$];
    int total = 0;
    int bad   = 0;
    int mdl_bundles = 0;
    int mdl_stall   = 0;

    // Reference decode: format from the opcode table, immediate built from
    // the documented bit fields and widened through signed variables.
    function automatic exp_t model(input logic [31:0] ins, input bit en);
        exp_t e;
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        logic signed [20:0] s21;
        logic signed [31:0] s32;
        logic signed [63:0] wide;
        e = '{fmt: 0, ill: 0, rs1: 0, rs2: 0, rd: 0, f3: 0, f7: 0, imm: 0};
        if (!en) return e;
        e.rd = ins[11:7]; e.f3 = ins[14:12]; e.rs1 = ins[19:15];
        e.rs2 = ins[24:20]; e.f7 = ins[31:25];
        wide = 0;
        case (ins[6:0])
            7'b0110011, 7'b0111011: e.fmt = 1;
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                e.fmt = 2; s12 = ins[31:20]; wide = s12;
            end
            7'b0100011: begin e.fmt = 3; s12 = {ins[31:25], ins[11:7]}; wide = s12; end
            7'b1100011: begin
                e.fmt = 4; s13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; wide = s13;
            end
            7'b0110111, 7'b0010111: begin e.fmt = 5; s32 = {ins[31:12], 12'b0}; wide = s32; end
            7'b1101111: begin
                e.fmt = 6; s21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; wide = s21;
            end
            default: begin e.fmt = 7; e.ill = 1; end
        endcase
        e.imm = wide;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        case ($urandom_range(0, 13))
            0: op = 7'b0110011;  1: op = 7'b0111011;  2: op = 7'b0010011;
            3: op = 7'b0011011;  4: op = 7'b0000011;  5: op = 7'b1100111;
            6: op = 7'b1110011;  7: op = 7'b0001111;  8: op = 7'b0100011;
            9: op = 7'b1100011; 10: op = 7'b0110111; 11: op = 7'b0010111;
            12: op = 7'b1101111;
            default: op = 7'($urandom);
        endcase
        return {25'($urandom), op};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare handshake state and, when a bundle is expected, every lane field.
    task automatic checkOutput();
        exp_t e;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        if (q.size() != 0) begin
            chk("out_mask", 64'(out_mask), 64'(q[0].mask));
            for (int l = 0; l < LANES; l++) begin
                e = model(q[0].instr[32*l +: 32], q[0].mask[l]);
                chk($sformatf("fmt_l%0d", l), 64'(out_fmt[3*l +: 3]), 64'(e.fmt));
                chk($sformatf("illegal_l%0d", l), 64'(out_illegal[l]), 64'(e.ill));
                chk($sformatf("rs1_l%0d", l), 64'(out_rs1[5*l +: 5]), 64'(e.rs1));
                chk($sformatf("rs2_l%0d", l), 64'(out_rs2[5*l +: 5]), 64'(e.rs2));
                chk($sformatf("rd_l%0d", l), 64'(out_rd[5*l +: 5]), 64'(e.rd));
                chk($sformatf("funct3_l%0d", l), 64'(out_funct3[3*l +: 3]), 64'(e.f3));
                chk($sformatf("funct7_l%0d", l), 64'(out_funct7[7*l +: 7]), 64'(e.f7));
                chk($sformatf("imm_l%0d", l), 64'(out_imm[XLEN*l +: XLEN]), 64'(e.imm[XLEN-1:0]));
            end
        end
    endtask

    // Drive one cycle of inputs, check outputs, then advance the model by the
    // handshakes that fire on the coming rising edge.
    task automatic applyStimulus(input bit v, input logic [LANES*32-1:0] ins,
                                 input logic [LANES-1:0] m, input bit ordy);
        bit acc, pop;
        bundle_t b;
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        in_mask   = m;
        out_ready = ordy;
        #1;
        checkOutput();
        acc = v && (q.size() != DEPTH);
        pop = ordy && (q.size() != 0);
        if (acc) mdl_bundles++;
        if (v && !acc) mdl_stall++;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) begin
            b.instr = ins;
            b.mask  = m;
            q.push_back(b);
        end
        #1;
    endtask

    initial begin
        $display("[TB] start");
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_imm", 64'(out_imm), 64'd0);
        chk("reset_fmt", 64'(out_fmt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // addi x1,x2,-1 / sw x5,8(x2)
        applyStimulus(1, {32'h00512423, 32'hFFF10093}, 2'b11, 1);
        chk("addi_fmt", 64'(out_fmt[2:0]), 64'd2);
        chk("addi_rd", 64'(out_rd[4:0]), 64'd1);
        chk("addi_rs1", 64'(out_rs1[4:0]), 64'd2);
        chk("addi_imm", 64'(out_imm[31:0]), 64'hFFFFFFFF);
        chk("sw_fmt", 64'(out_fmt[5:3]), 64'd3);
        chk("sw_rs2", 64'(out_rs2[9:5]), 64'd5);
        chk("sw_imm", 64'(out_imm[63:32]), 64'h00000008);

        // beq x0,x0,-4 / lui x3,0x12345
        applyStimulus(1, {32'h123451B7, 32'hFE000EE3}, 2'b11, 1);
        chk("beq_fmt", 64'(out_fmt[2:0]), 64'd4);
        chk("beq_imm", 64'(out_imm[31:0]), 64'hFFFFFFFC);
        chk("lui_fmt", 64'(out_fmt[5:3]), 64'd5);
        chk("lui_rd", 64'(out_rd[9:5]), 64'd3);
        chk("lui_imm", 64'(out_imm[63:32]), 64'h12345000);

        // illegal lane0, masked-out lane1 carrying non-zero bits
        applyStimulus(1, {32'hFFFFFFFF, 32'h00000000}, 2'b01, 1);
        chk("ill_fmt", 64'(out_fmt[2:0]), 64'd7);
        chk("ill_flag", 64'(out_illegal), 64'b01);
        chk("none_lane", 64'({out_fmt[5:3], out_rd[9:5], out_rs1[9:5], out_imm[63:32]}), 64'd0);

        // Fill with consumer stalled, offer a third, then drain
        applyStimulus(1, {32'h00A00513, 32'h00B00593}, 2'b11, 0);
        applyStimulus(1, {32'h40B50533, 32'h0000006F}, 2'b11, 0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(1, {32'h00C0006F, 32'h00112023}, 2'b11, 0);
        applyStimulus(1, {32'h00C0006F, 32'h00112023}, 2'b11, 1);
        applyStimulus(1, {32'h00C0006F, 32'h00112023}, 2'b11, 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, '0, '0, 1);

        // Asynchronous reset while full
        applyStimulus(1, {32'h00A00513, 32'h00B00593}, 2'b11, 0);
        applyStimulus(1, {32'h40B50533, 32'hFFF10093}, 2'b11, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_imm", 64'(out_imm), 64'd0);
        q.delete();
        mdl_bundles = 0;
        mdl_stall   = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) applyStimulus(0, '0, '0, 1);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            applyStimulus(($urandom_range(0, 3) != 0), {rand_instr(), rand_instr()},
                          2'($urandom), ($urandom_range(0, 2) != 0));
        end
        for (int k = 0; k < 3; k++) applyStimulus(0, '0, '0, 1);

`ifdef DECODE_FIELD_STAGE_PERF_EN
        chk("perf_bundles_rand", 64'(perf_bundles), 64'(mdl_bundles));
        chk("perf_stall_rand", 64'(perf_stall), 64'(mdl_stall));
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(1, {rand_instr(), rand_instr()}, 2'b11, 1);
        applyStimulus(0, '0, '0, 1);
        for (int k = 0; k < 5; k++) applyStimulus(1, {rand_instr(), rand_instr()}, 2'b11, 0);
        @(negedge clk);
        chk("perf_bundles", 64'(perf_bundles), 64'd5);
        chk("perf_stall", 64'(perf_stall), 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_field_stage.md
Name: decode_field_stage

Overview:
- Registered, multi-lane successor to the single-lane combinational field extractor. Accepts a bundle of LANES raw 32-bit instructions per handshake.
- Classifies each lane by full 7-bit opcode into R/I/S/B/U/J format, or flags it illegal. Extracts register fields and produces a fully assembled, sign-extended XLEN-bit immediate.
- Sits between fetch queue and rename; outputs are buffered in a small FIFO with valid/ready on both sides.

Parameters:
- LANES, 2, instructions per bundle (1..4)
- XLEN, 32, immediate output width (32 or 64); sign-extend from instruction bit 31
- DEPTH, 2, output buffer entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  bundle offered
- in_ready  out  1  stage can accept bundle
- in_instr  in  LANES*32  lane i at [32*i+31:32*i]
- in_mask  in  LANES  lane i holds a real instruction
- out_valid  out  1  head bundle valid
- out_ready  in  1  consumer accepts head
- out_mask  out  LANES  registered copy of in_mask
- out_fmt  out  LANES*3  per-lane format code (package enum)
- out_illegal  out  LANES  unknown opcode on a masked-in lane
- out_rs1, out_rs2, out_rd  out  LANES*5 each  register fields
- out_funct3  out  LANES*3  funct3
- out_funct7  out  LANES*7  funct7
- out_imm  out  LANES*XLEN  sign-extended immediate

Behaviour:
- Reset, asynchronous, any cycle including mid-transfer:
  - count=0, rd/wr pointers=0, out_valid=0, in_ready=1.
  - All out_* data reads zero.
  - Buffered bundles are discarded; nothing is replayed.
- Accept: in_valid & in_ready. Decode is combinational per lane; the result is written into the FIFO at wr_ptr on the same edge.
- Latency: bundle accepted at edge N appears with out_valid=1 after edge N (one cycle) when the FIFO was empty.
- in_ready = (count != DEPTH). It is registered-state-only, with no combinational path from out_ready.
- Pop: out_valid & out_ready; rd_ptr advances.
- Simultaneous push and pop: count unchanged, pointers both advance, order preserved.
- Pointer wrap: modulo DEPTH.
- Full: in_ready=0; in_instr is ignored.
- Empty: out_valid=0; out_* data is held at last value (don't-care to consumer).
- Head stability: while out_valid & !out_ready, every out_* signal is stable.
- Field extraction, all formats: rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- Formats and immediates (all immediates sign-extended to XLEN):
  - R, opcodes 0110011/0111011: imm=0
  - I, opcodes 0010011/0011011/0000011/1100111/1110011/0001111: imm=sext([31:20])
  - S, opcode 0100011: imm=sext({[31:25],[11:7]})
  - B, opcode 1100011: imm=sext({[31],[7],[30:25],[11:8],0})
  - U, opcodes 0110111/0010111: imm=sext({[31:12],12'b0})
  - J, opcode 1101111: imm=sext({[31],[19:12],[20],[30:21],0})
- Illegal lanes: any other opcode on a masked-in lane gives fmt=ILL, illegal=1, imm=0. Register fields are still extracted.
- Masked-out lanes: fmt=NONE, illegal=0, all fields and imm zero.
- XLEN=32 with U-format: imm equals {[31:12],12'b0} with no extension.

Optional Feature:
- Macro: DECODE_FIELD_STAGE_PERF_EN
- When defined:
  - Adds outputs perf_bundles (32 bits), counting accepted bundles.
  - Adds perf_stall (32 bits), counting cycles with in_valid & !in_ready.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package decode_pkg holds:
  - fmt enum: NONE=0, R=1, I=2, S=3, B=4, U=5, J=6, ILL=7
  - 7-bit opcode constants
  - the lane-result struct {fmt, illegal, rs1, rs2, rd, funct3, funct7, imm}
- Sub-module decode_lane: purely combinational single-lane classify, extract and immediate generation. It is instantiated LANES times via generate.
- The top holds the FIFO storage, pointers, count and handshake.

Test Plan:
- LANES=2, lane0=0xFFF10093 (addi x1,x2,-1), lane1=0x00512423 (sw x5,8(x2)), mask=11 -> next cycle:
  - lane0: fmt I, rd=1, rs1=2, imm=0xFFFFFFFF
  - lane1: fmt S, rs1=2, rs2=5, imm=0x00000008
- lane0=0xFE000EE3 (beq x0,x0,-4), lane1=0x123451B7 (lui x3,0x12345) -> lane0 imm=0xFFFFFFFC fmt B; lane1 imm=0x12345000 fmt U rd=3.
- lane0=0x00000000, mask=01 -> lane0 fmt ILL illegal=1; lane1 fmt NONE illegal=0 all zero.
- out_ready=0, push 3 bundles with DEPTH=2 -> in_ready falls after 2nd accept; 3rd held. Raise out_ready -> pops in order, 3rd accepted, same-cycle push/pop keeps count=2.
- Assert rst while FIFO holds 2 bundles -> out_valid=0 and in_ready=1 immediately (asynchronously). Stale bundles never appear after release.
- With DECODE_FIELD_STAGE_PERF_EN: 5 accepts plus 3 stalled cycles -> perf_bundles=5, perf_stall=3.
